// File: rtl/multi_chan_seen_pkg.sv
// ============================================================================
// Module   : multi_chan_seen_pkg
// Purpose  : Shared state encoding for the N-channel all-seen tracker.
// Contents : state_t - 2-bit FSM state type
//               ST_IDLE    = 2'd0  no channel seen since the last idle
//               ST_COLLECT = 2'd1  some, but not all, channels seen
//               ST_FULL    = 2'd2  every channel seen; waiting for all to drop
//            Code 2'd3 is unused and recovers to ST_IDLE.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package multi_chan_seen_pkg;

   localparam int c_STATE_W = 2;

   typedef enum logic [c_STATE_W-1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_FULL    = 2'd2
   } state_t;

endpackage : multi_chan_seen_pkg

`default_nettype wire

// File: rtl/seen_timeout_ctr.sv
// ============================================================================
// Module   : seen_timeout_ctr
// Purpose  : No-progress timer for the all-seen tracker. Counts cycles while
//            inc is high, saturating at all-ones so it never wraps.
// Ports    : clk    in  1  clock
//            rst    in  1  asynchronous active-high reset
//            clr    in  1  synchronous clear (has priority over inc)
//            inc    in  1  count enable
//            expire out 1  high while the count sits at TIMEOUT-1
//                          (never high when TIMEOUT is 0)
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seen_timeout_ctr #(
   parameter int TMO_W   = 8,
   parameter int TIMEOUT = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expire
);

   // For TIMEOUT==0 this constant is meaningless; expire is gated off below.
   localparam logic [TMO_W-1:0] c_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [TMO_W-1:0] c_MAX  = '1;

   logic [TMO_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != c_MAX)) begin
         r_cnt <= r_cnt + TMO_W'(1);
      end
   end

   assign expire = (TIMEOUT != 0) && (r_cnt == c_LAST);

endmodule : seen_timeout_ctr

`default_nettype wire

// File: rtl/multi_chan_seen_fsm.sv
// ============================================================================
// Module   : multi_chan_seen_fsm
// Purpose  : N-channel "all-seen" tracker. Accumulates which request lines
//            have asserted since the last idle, reports completion once all
//            have been seen, then waits for every line to drop. A stalled
//            collection (no new channel for TIMEOUT cycles) is aborted with a
//            one-cycle timeout_o pulse.
// Ports    : clk       in  1      clock
//            rst       in  1      asynchronous active-high reset
//            ch_in     in  N_CH   channel activity lines
//            idle      out 1      state is IDLE
//            all_seen  out 1      state is FULL
//            seen      out N_CH   channels seen during this pass
//            state_o   out 2      IDLE=0, COLLECT=1, FULL=2
//            timeout_o out 1      one-cycle pulse on a timeout abort
//            pass_cnt  out CNT_W  saturating count of entries into FULL
//                                 (present only when SEEN_CNT_EN is defined)
// Config   : `define SEEN_CNT_EN to build the pass counter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module multi_chan_seen_fsm
   import multi_chan_seen_pkg::*;
#(
   parameter int N_CH    = 2,
   parameter int TMO_W   = 8,
   parameter int TIMEOUT = 0,
   parameter int CNT_W   = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] ch_in,
   output logic            idle,
   output logic            all_seen,
   output logic [N_CH-1:0] seen,
   output logic [1:0]      state_o,
   output logic            timeout_o
`ifdef SEEN_CNT_EN
   ,
   output logic [CNT_W-1:0] pass_cnt
`endif
);

   localparam logic [N_CH-1:0] c_ALL = '1;

   state_t          r_state;
   logic [N_CH-1:0] r_seen;
   logic            r_idle;
   logic            r_all_seen;
   logic            r_timeout;

   logic [N_CH-1:0] w_nxt;
   logic            w_new;
   logic            w_done;
   logic            w_in_collect;
   logic            w_tmr_clr;
   logic            w_tmr_inc;
   logic            w_expire;
   logic            w_enter_full;

   assign w_nxt        = r_seen | ch_in;
   assign w_new        = (w_nxt != r_seen);
   assign w_done       = (w_nxt == c_ALL);
   assign w_in_collect = (r_state == ST_COLLECT);

   // The timer only runs in COLLECT while nothing new arrives. Completion in
   // COLLECT always implies a new bit, so w_new also covers that case.
   assign w_tmr_clr = !w_in_collect || w_new || w_expire;
   assign w_tmr_inc = !w_tmr_clr;

   assign w_enter_full = ((r_state == ST_IDLE) && (ch_in == c_ALL)) ||
                         (w_in_collect && w_done);

   seen_timeout_ctr #(
      .TMO_W   (TMO_W),
      .TIMEOUT (TIMEOUT)
   ) u_tmr (
      .clk    (clk),
      .rst    (rst),
      .clr    (w_tmr_clr),
      .inc    (w_tmr_inc),
      .expire (w_expire)
   );

   // idle/all_seen are registered alongside the state so every output comes
   // straight from a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_seen     <= '0;
         r_idle     <= 1'b1;
         r_all_seen <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (ch_in == c_ALL) begin
                  r_state    <= ST_FULL;
                  r_seen     <= c_ALL;
                  r_idle     <= 1'b0;
                  r_all_seen <= 1'b1;
               end else if (ch_in != '0) begin
                  r_state    <= ST_COLLECT;
                  r_seen     <= ch_in;
                  r_idle     <= 1'b0;
                  r_all_seen <= 1'b0;
               end
            end
            ST_COLLECT: begin
               r_seen <= w_nxt;
               if (w_done) begin
                  // Completion takes priority over an expiry on the same cycle.
                  r_state    <= ST_FULL;
                  r_idle     <= 1'b0;
                  r_all_seen <= 1'b1;
               end else if (!w_new && w_expire) begin
                  r_state    <= ST_IDLE;
                  r_seen     <= '0;
                  r_idle     <= 1'b1;
                  r_all_seen <= 1'b0;
                  r_timeout  <= 1'b1;
               end
            end
            ST_FULL: begin
               if (ch_in == '0) begin
                  r_state    <= ST_IDLE;
                  r_seen     <= '0;
                  r_idle     <= 1'b1;
                  r_all_seen <= 1'b0;
               end
            end
            default: begin
               // Unused code: recover quietly to IDLE.
               r_state    <= ST_IDLE;
               r_seen     <= '0;
               r_idle     <= 1'b1;
               r_all_seen <= 1'b0;
            end
         endcase
      end
   end

   assign idle      = r_idle;
   assign all_seen  = r_all_seen;
   assign seen      = r_seen;
   assign state_o   = r_state;
   assign timeout_o = r_timeout;

`ifdef SEEN_CNT_EN
   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   logic [CNT_W-1:0] r_pass_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pass_cnt <= '0;
      end else if (w_enter_full && (r_pass_cnt != c_CNT_MAX)) begin
         r_pass_cnt <= r_pass_cnt + CNT_W'(1);
      end
   end

   assign pass_cnt = r_pass_cnt;
`endif

endmodule : multi_chan_seen_fsm

`default_nettype wire

// File: tb/tb_multi_chan_seen_fsm.sv
// ============================================================================
// Module   : tb_multi_chan_seen_fsm
// Purpose  : Self-checking bench for multi_chan_seen_fsm (N_CH=2, TIMEOUT=4).
//            Pass-counter checks are built when SEEN_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multi_chan_seen_fsm;

   localparam int N_CH    = 2;
   localparam int TMO_W   = 8;
   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 2;
   localparam int ALL     = (1 << N_CH) - 1;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic            clk;
   logic            rst;
   logic [N_CH-1:0] ch_in;
   logic            idle;
   logic            all_seen;
   logic [N_CH-1:0] seen;
   logic [1:0]      state_o;
   logic            timeout_o;
`ifdef SEEN_CNT_EN
   logic [CNT_W-1:0] pass_cnt;
`endif

   int n_checks = 0;
   int n_err    = 0;
   bit cmp_on   = 1'b0;

   multi_chan_seen_fsm #(
      .N_CH    (N_CH),
      .TMO_W   (TMO_W),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ch_in     (ch_in),
      .idle      (idle),
      .all_seen  (all_seen),
      .seen      (seen),
      .state_o   (state_o),
      .timeout_o (timeout_o)
`ifdef SEEN_CNT_EN
      ,
      .pass_cnt  (pass_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- model
   // mode: 0 idle, 1 collecting, 2 full. stall = number of collecting cycles
   // spent since the last progress (entry or new channel), counting this one.
   typedef struct {
      int mode;
      int seen;
      int stall;
      int passes;
      bit pulse;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.mode = 0; r.seen = 0; r.stall = 0; r.passes = 0; r.pulse = 1'b0;
      return r;
   endfunction

   function automatic model_t step(model_t cur, int ch);
      model_t n = cur;
      int     u = cur.seen | ch;
      n.pulse = 1'b0;
      if (cur.mode == 0) begin
         if (ch == ALL) begin
            n.mode = 2; n.seen = ALL;
            if (n.passes < CNT_MAX) n.passes++;
         end else if (ch != 0) begin
            n.mode = 1; n.seen = ch; n.stall = 1;
         end
      end else if (cur.mode == 1) begin
         if (u == ALL) begin
            n.mode = 2; n.seen = ALL;
            if (n.passes < CNT_MAX) n.passes++;
         end else if (u != cur.seen) begin
            n.seen = u; n.stall = 1;
         end else if (TIMEOUT != 0 && cur.stall == TIMEOUT) begin
            n.mode = 0; n.seen = 0; n.stall = 0; n.pulse = 1'b1;
         end else begin
            n.stall = cur.stall + 1;
         end
      end else begin
         if (ch == 0) begin
            n.mode = 0; n.seen = 0;
         end
      end
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m <= model_reset();
      else     m <= step(m, int'(ch_in));
   end

   // -------------------------------------------------------------- compare
   always @(negedge clk) begin
      if (cmp_on) begin
         n_checks++;
         if (int'(state_o) !== m.mode || int'(seen) !== m.seen ||
             idle !== (m.mode == 0) || all_seen !== (m.mode == 2) ||
             timeout_o !== m.pulse) begin
            n_err++;
            $display("FAIL model_cmp t=%0t got state=%0d seen=%b idle=%b all=%b tmo=%b want state=%0d seen=%0d idle=%0d all=%0d tmo=%0d",
                     $time, state_o, seen, idle, all_seen, timeout_o,
                     m.mode, m.seen, (m.mode == 0), (m.mode == 2), m.pulse);
         end
`ifdef SEEN_CNT_EN
         n_checks++;
         if (int'(pass_cnt) !== m.passes) begin
            n_err++;
            $display("FAIL model_pass_cnt t=%0t got=%0d want=%0d", $time, pass_cnt, m.passes);
         end
`endif
      end
   end

   // ------------------------------------------------------ directed checks
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
      end
   endtask

   task automatic cyc(input logic [N_CH-1:0] v);
      ch_in = v;
      @(posedge clk);
      #2;
   endtask

`ifdef SEEN_CNT_EN
   int exp_pc[5] = '{1, 2, 3, 3, 3};
`endif

   initial begin
      rst   = 1'b1;
      ch_in = '0;
      #1 cmp_on = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      // reset state
      chk("rst_idle",   32'(idle),      32'd1);
      chk("rst_state",  32'(state_o),   32'd0);
      chk("rst_seen",   32'(seen),      32'd0);
      chk("rst_all",    32'(all_seen),  32'd0);
      chk("rst_tmo",    32'(timeout_o), 32'd0);

      // partial then complete
      cyc(2'b01);
      chk("p1_state", 32'(state_o), 32'd1);
      chk("p1_seen",  32'(seen),    32'h1);
      cyc(2'b10);
      chk("p1_full",  32'(state_o), 32'd2);
      chk("p1_all",   32'(all_seen), 32'd1);
      chk("p1_seen3", 32'(seen),    32'h3);
      cyc(2'b00);
      chk("p1_idle",  32'(idle),    32'd1);
      chk("p1_seen0", 32'(seen),    32'h0);

      // direct jump
      cyc(2'b11);
      chk("dj_full",  32'(state_o), 32'd2);
      cyc(2'b11);
      chk("dj_hold",  32'(state_o), 32'd2);
      cyc(2'b00);
      chk("dj_idle",  32'(idle),    32'd1);

      // timeout: four collecting cycles then abort
      cyc(2'b01);
      chk("to_c0", 32'(state_o), 32'd1);
      for (int i = 1; i < 4; i++) begin
         cyc(2'b01);
         chk("to_cn", 32'(state_o), 32'd1);
         chk("to_nopulse", 32'(timeout_o), 32'd0);
      end
      cyc(2'b01);
      chk("to_idle",  32'(state_o),   32'd0);
      chk("to_seen",  32'(seen),      32'h0);
      chk("to_pulse", 32'(timeout_o), 32'd1);
      cyc(2'b00);
      chk("to_pulse_end", 32'(timeout_o), 32'd0);

      // completion beats timeout on the expiry cycle
      cyc(2'b01);
      cyc(2'b01);
      cyc(2'b01);
      cyc(2'b01);
      chk("cb_collect", 32'(state_o), 32'd1);
      cyc(2'b10);
      chk("cb_full", 32'(state_o),   32'd2);
      chk("cb_tmo",  32'(timeout_o), 32'd0);
      cyc(2'b00);

      // async reset between edges
      cyc(2'b01);
      chk("ar_pre", 32'(seen), 32'h1);
      #1 rst = 1'b1;
      #1;
      chk("ar_idle",  32'(idle),      32'd1);
      chk("ar_seen",  32'(seen),      32'h0);
      chk("ar_state", 32'(state_o),   32'd0);
      chk("ar_tmo",   32'(timeout_o), 32'd0);
      #2 rst = 1'b0;
      cyc(2'b00);
      chk("ar_stay", 32'(idle), 32'd1);

`ifdef SEEN_CNT_EN
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      chk("pc_rst0", 32'(pass_cnt), 32'd0);
      for (int i = 0; i < 5; i++) begin
         cyc(2'b11);
         chk("pc_pass", 32'(pass_cnt), 32'(exp_pc[i]));
         cyc(2'b00);
      end
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      chk("pc_rst1", 32'(pass_cnt), 32'd0);
`endif

      cyc(2'b00);
      cmp_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_multi_chan_seen_fsm

`default_nettype wire
